// File: rtl/wmst_out_fm_burst_ctrl.sv
// Output-feature-map store controller: sequences Avalon write bursts
// that move one output tile from the store FIFO into DDR.
module wmst_out_fm_burst_ctrl #(
  parameter int CW        = 16,
  parameter int XAW       = 32,
  parameter int FCW       = 8,
  parameter int Tn        = 16,
  parameter int Tr        = 64,
  parameter int Tc        = 16,
  parameter int K         = 3,
  parameter int S         = 1,
  parameter int MAX_BURST = 16,
  parameter int WB_LOG2   = 2,
  parameter int OUT_BASE  = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           store_start,
  input  logic           store_abort,
  input  logic [CW-1:0]  tile_base_n,
  input  logic [CW-1:0]  tile_base_row,
  input  logic [CW-1:0]  tile_base_col,
  input  logic [CW-1:0]  cfg_n,
  input  logic [CW-1:0]  cfg_r,
  input  logic [CW-1:0]  cfg_c,
  input  logic [FCW-1:0] store_fifo_count,
  output logic           store_trans_start,
  output logic [XAW-1:0] param_waddr,
  output logic [CW-1:0]  param_iolen,
  input  logic           store_trans_done,
  output logic           store_busy,
  output logic           store_done
);

  localparam int TR_STEP = ((Tr + S - K) / S) * S;
  localparam int TC_STEP = ((Tc + S - K) / S) * S;

  localparam logic [CW-1:0] TN_C = CW'(Tn);
  localparam logic [CW-1:0] TR_C = CW'(TR_STEP);
  localparam logic [CW-1:0] TC_C = CW'(TC_STEP);
  localparam logic [CW-1:0] MB_C = CW'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_WAIT,
    S_CONFIG,
    S_TRANS,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]  bn_q, bn_d;
  logic [CW-1:0]  br_q, br_d;
  logic [CW-1:0]  bc_q, bc_d;
  logic [CW-1:0]  cr_q, cr_d;
  logic [CW-1:0]  cc_q, cc_d;
  logic [CW-1:0]  vn_q, vn_d;
  logic [CW-1:0]  vr_q, vr_d;
  logic [CW-1:0]  vc_q, vc_d;
  logic [CW-1:0]  tn_q, tn_d;
  logic [CW-1:0]  tr_q, tr_d;
  logic [CW-1:0]  tc_q, tc_d;
  logic [XAW-1:0] waddr_q, waddr_d;
  logic [CW-1:0]  iolen_q, iolen_d;
  logic           tstart_q, tstart_d;

  logic [CW-1:0]  rem;
  logic [CW-1:0]  blen;
  logic [CW-1:0]  fifo_w;
  logic [CW-1:0]  tc_nx;
  logic [CW-1:0]  tr_nx;
  logic [CW-1:0]  tn_nx;
  logic [XAW-1:0] ch_x;
  logic [XAW-1:0] row_x;
  logic [XAW-1:0] col_x;
  logic [XAW-1:0] word_x;

  // Remaining extent clipped to the tile step; zero once base is past it.
  function automatic logic [CW-1:0] sat_len(
    input logic [CW-1:0] ext,
    input logic [CW-1:0] base,
    input logic [CW-1:0] lim
  );
    logic [CW-1:0] d;
    if (base >= ext) begin
      return '0;
    end
    d = ext - base;
    return (d > lim) ? lim : d;
  endfunction

  assign rem    = vc_q - tc_q;
  assign blen   = (rem > MB_C) ? MB_C : rem;
  assign fifo_w = CW'(store_fifo_count);
  assign tc_nx  = tc_q + blen;
  assign tr_nx  = tr_q + 1'b1;
  assign tn_nx  = tn_q + 1'b1;

  assign ch_x   = XAW'(bn_q) + XAW'(tn_q);
  assign row_x  = XAW'(br_q) + XAW'(tr_q);
  assign col_x  = XAW'(bc_q) + XAW'(tc_q);
  assign word_x = XAW'(OUT_BASE)
                + ch_x * XAW'(cr_q) * XAW'(cc_q)
                + row_x * XAW'(cc_q)
                + col_x;

  always_comb begin
    state_d  = state_q;
    bn_d     = bn_q;
    br_d     = br_q;
    bc_d     = bc_q;
    cr_d     = cr_q;
    cc_d     = cc_q;
    vn_d     = vn_q;
    vr_d     = vr_q;
    vc_d     = vc_q;
    tn_d     = tn_q;
    tr_d     = tr_q;
    tc_d     = tc_q;
    waddr_d  = waddr_q;
    iolen_d  = iolen_q;
    tstart_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (store_start) begin
          bn_d    = tile_base_n;
          br_d    = tile_base_row;
          bc_d    = tile_base_col;
          cr_d    = cfg_r;
          cc_d    = cfg_c;
          vn_d    = sat_len(cfg_n, tile_base_n, TN_C);
          vr_d    = sat_len(cfg_r, tile_base_row, TR_C);
          vc_d    = sat_len(cfg_c, tile_base_col, TC_C);
          tn_d    = '0;
          tr_d    = '0;
          tc_d    = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (vn_q == '0 || vr_q == '0 || vc_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fifo_w >= blen) begin
          state_d = S_CONFIG;
        end
      end
      S_CONFIG: begin
        waddr_d  = word_x << WB_LOG2;
        iolen_d  = blen;
        tstart_d = 1'b1;
        state_d  = S_TRANS;
      end
      S_TRANS: begin
        if (store_trans_done) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        state_d = S_WAIT;
        tc_d    = tc_nx;
        if (tc_nx >= vc_q) begin
          tc_d = '0;
          tr_d = tr_nx;
          if (tr_nx >= vr_q) begin
            tr_d = '0;
            tn_d = tn_nx;
            if (tn_nx >= vn_q) begin
              tn_d    = '0;
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort overrides everything, including a same-cycle trans_done.
    if (store_abort) begin
      state_d  = S_IDLE;
      tn_d     = '0;
      tr_d     = '0;
      tc_d     = '0;
      tstart_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bn_q     <= '0;
      br_q     <= '0;
      bc_q     <= '0;
      cr_q     <= '0;
      cc_q     <= '0;
      vn_q     <= '0;
      vr_q     <= '0;
      vc_q     <= '0;
      tn_q     <= '0;
      tr_q     <= '0;
      tc_q     <= '0;
      waddr_q  <= '0;
      iolen_q  <= '0;
      tstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bn_q     <= bn_d;
      br_q     <= br_d;
      bc_q     <= bc_d;
      cr_q     <= cr_d;
      cc_q     <= cc_d;
      vn_q     <= vn_d;
      vr_q     <= vr_d;
      vc_q     <= vc_d;
      tn_q     <= tn_d;
      tr_q     <= tr_d;
      tc_q     <= tc_d;
      waddr_q  <= waddr_d;
      iolen_q  <= iolen_d;
      tstart_q <= tstart_d;
    end
  end

  assign store_trans_start = tstart_q;
  assign param_waddr       = waddr_q;
  assign param_iolen       = iolen_q;
  assign store_busy        = (state_q != S_IDLE);
  assign store_done        = (state_q == S_DONE);

endmodule

// File: tb/tb_wmst_out_fm_burst_ctrl.sv
// Bench for wmst_out_fm_burst_ctrl: burst sequences are predicted by
// nested tile loops and compared burst-by-burst on two parameter sets.
module tb_wmst_out_fm_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] bn = '0;
  logic [15:0] br = '0;
  logic [15:0] bc = '0;
  logic [15:0] cn = '0;
  logic [15:0] cr = '0;
  logic [15:0] cc = '0;
  logic [7:0]  fifo = 8'd255;
  logic        done0 = 1'b0;
  logic        done1 = 1'b0;
  logic        ts0, ts1, busy0, busy1, sd0, sd1;
  logic [31:0] wa0, wa1;
  logic [15:0] il0, il1;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wmst_out_fm_burst_ctrl dut (
    .clk(clk), .rst(rst), .store_start(start0), .store_abort(abort),
    .tile_base_n(bn), .tile_base_row(br), .tile_base_col(bc),
    .cfg_n(cn), .cfg_r(cr), .cfg_c(cc), .store_fifo_count(fifo),
    .store_trans_start(ts0), .param_waddr(wa0), .param_iolen(il0),
    .store_trans_done(done0), .store_busy(busy0), .store_done(sd0)
  );

  wmst_out_fm_burst_ctrl #(.Tc(40)) dut2 (
    .clk(clk), .rst(rst), .store_start(start1), .store_abort(abort),
    .tile_base_n(bn), .tile_base_row(br), .tile_base_col(bc),
    .cfg_n(cn), .cfg_r(cr), .cfg_c(cc), .store_fifo_count(fifo),
    .store_trans_start(ts1), .param_waddr(wa1), .param_iolen(il1),
    .store_trans_done(done1), .store_busy(busy1), .store_done(sd1)
  );

  function automatic logic g_ts(int sel);
    return (sel == 0) ? ts0 : ts1;
  endfunction
  function automatic logic [31:0] g_wa(int sel);
    return (sel == 0) ? wa0 : wa1;
  endfunction
  function automatic logic [15:0] g_il(int sel);
    return (sel == 0) ? il0 : il1;
  endfunction
  function automatic logic g_busy(int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction
  function automatic logic g_sd(int sel);
    return (sel == 0) ? sd0 : sd1;
  endfunction

  task automatic set_start(int sel, logic v);
    if (sel == 0) start0 = v; else start1 = v;
  endtask
  task automatic set_done(int sel, logic v);
    if (sel == 0) done0 = v; else done1 = v;
  endtask

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic pulse_start(int sel, int b_n, int b_r, int b_c,
                             int n, int r, int c);
    @(negedge clk);
    bn = 16'(b_n); br = 16'(b_r); bc = 16'(b_c);
    cn = 16'(n); cr = 16'(r); cc = 16'(c);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
  endtask

  task automatic pulse_done(int sel);
    set_done(sel, 1'b1);
    @(negedge clk);
    set_done(sel, 1'b0);
  endtask

  task automatic wait_ts(int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (g_ts(sel)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_sd(int sel, string nm);
    bit got = 1'b0;
    bit extra = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (g_sd(sel)) begin
        got = 1'b1;
        break;
      end
      if (g_ts(sel)) extra = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!got || extra) begin
      fails++;
      $display("FAIL %s_done: got=%0d extra_start=%0d required got=1 extra=0",
               nm, got, extra);
    end
    @(negedge clk);
    checks++;
    if (g_busy(sel) !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy_after_done: got %b required 0", nm, g_busy(sel));
    end
  endtask

  // Reference: walk channels, rows, then column chunks of the clipped tile.
  task automatic run_tile(int sel, int b_n, int b_r, int b_c,
                          int n, int r, int c, int tcs, int mb,
                          bit poke, bit rndf, string nm);
    logic [31:0] qa[$];
    logic [15:0] qi[$];
    int vn, vr, vc;
    longint unsigned w;
    vn = (b_n >= n) ? 0 : imin(16, n - b_n);
    vr = (b_r >= r) ? 0 : imin(62, r - b_r);
    vc = (b_c >= c) ? 0 : imin(tcs, c - b_c);
    for (int tn = 0; tn < vn; tn++)
      for (int tr = 0; tr < vr; tr++)
        for (int tc = 0; tc < vc; tc += imin(mb, vc - tc)) begin
          w = longint'(b_n + tn) * r * c + longint'(b_r + tr) * c + b_c + tc;
          qa.push_back(32'(w << 2));
          qi.push_back(16'(imin(mb, vc - tc)));
        end
    pulse_start(sel, b_n, b_r, b_c, n, r, c);
    for (int i = 0; i < qa.size(); i++) begin
      bit seen = 1'b0;
      int to = 0;
      int p_last = int'(fifo);
      int p_prev = int'(fifo);
      while (!seen && to < 300) begin
        if (g_ts(sel)) begin
          seen = 1'b1;
        end else begin
          to++;
          if (rndf) begin
            p_prev = p_last;
            fifo = 8'($urandom_range(0, 20));
            p_last = int'(fifo);
          end else begin
            p_prev = p_last;
          end
          @(negedge clk);
        end
      end
      checks++;
      if (!seen) begin
        fails++;
        $display("FAIL %s_timeout burst %0d: no trans_start", nm, i);
        fifo = 8'd255;
        return;
      end
      checks++;
      if (g_wa(sel) !== qa[i] || g_il(sel) !== qi[i]) begin
        fails++;
        $display("FAIL %s_burst%0d: waddr=%0d iolen=%0d required %0d %0d",
                 nm, i, g_wa(sel), g_il(sel), qa[i], qi[i]);
      end
      if (rndf) begin
        checks++;
        if (p_prev < int'(qi[i])) begin
          fails++;
          $display("FAIL %s_fifo%0d: launched at count %0d required >= %0d",
                   nm, i, p_prev, qi[i]);
        end
      end
      if (poke && i == 0) begin
        bn = 16'd3; br = 16'd1; bc = 16'd2;
        cn = 16'd5; cr = 16'd5; cc = 16'd5;
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_done(sel);
    end
    fifo = 8'd255;
    wait_sd(sel, nm);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ts0, wa0, il0, busy0, sd0} !== '0 ||
        {ts1, wa1, il1, busy1, sd1} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: dut=%h dut2=%h required 0",
               {ts0, wa0, il0, busy0, sd0}, {ts1, wa1, il1, busy1, sd1});
    end
    rst = 1'b0;
  endtask

  task automatic test_full_tile();
    run_tile(0, 0, 0, 0, 32, 62, 30, 14, 16, 1'b0, 1'b0, "full");
  endtask

  task automatic test_row_split();
    run_tile(1, 0, 0, 0, 1, 2, 64, 38, 16, 1'b0, 1'b0, "split");
  endtask

  task automatic test_partial_channels();
    bit bad_ts = 1'b0;
    run_tile(0, 24, 0, 0, 32, 3, 10, 14, 16, 1'b0, 1'b0, "partn");
    pulse_start(0, 32, 0, 0, 32, 3, 10);
    bad_ts = ts0;
    checks++;
    if (sd0 !== 1'b0 || busy0 !== 1'b1) begin
      fails++;
      $display("FAIL empty_calc: done=%b busy=%b required 0 1", sd0, busy0);
    end
    @(negedge clk);
    bad_ts = bad_ts | ts0;
    checks++;
    if (sd0 !== 1'b1 || bad_ts) begin
      fails++;
      $display("FAIL empty_done: done=%b ts=%b required 1 0", sd0, bad_ts);
    end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      fails++;
      $display("FAIL empty_idle: busy=%b required 0", busy0);
    end
  endtask

  task automatic test_fifo_wait();
    bit any_ts = 1'b0;
    fifo = 8'd5;
    pulse_start(0, 0, 0, 0, 1, 1, 30);
    repeat (10) begin
      any_ts = any_ts | ts0;
      @(negedge clk);
    end
    checks++;
    if (any_ts || busy0 !== 1'b1) begin
      fails++;
      $display("FAIL fifo_hold: ts=%b busy=%b required 0 1", any_ts, busy0);
    end
    fifo = 8'd14;
    @(negedge clk);
    checks++;
    if (ts0 !== 1'b0) begin
      fails++;
      $display("FAIL fifo_early: ts=%b required 0", ts0);
    end
    @(negedge clk);
    checks++;
    if (ts0 !== 1'b1 || wa0 !== 32'd0 || il0 !== 16'd14) begin
      fails++;
      $display("FAIL fifo_launch: ts=%b waddr=%0d iolen=%0d required 1 0 14",
               ts0, wa0, il0);
    end
    fifo = 8'd255;
    pulse_done(0);
    wait_sd(0, "fifo");
  endtask

  task automatic test_abort();
    bit ok;
    bit bad = 1'b0;
    pulse_start(0, 1, 2, 3, 4, 8, 20);
    wait_ts(0, ok);
    pulse_done(0);
    wait_ts(0, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL abort_setup: trans_start not seen");
    end
    done0 = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    done0 = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy0 !== 1'b0) begin
      fails++;
      $display("FAIL abort_busy: got %b required 0", busy0);
    end
    repeat (6) begin
      bad = bad | sd0 | ts0;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      fails++;
      $display("FAIL abort_quiet: done/start seen after abort");
    end
    run_tile(0, 1, 2, 3, 4, 8, 20, 14, 16, 1'b0, 1'b0, "restart");
  endtask

  task automatic test_async_reset();
    bit ok;
    pulse_start(0, 1, 0, 0, 2, 4, 8);
    wait_ts(0, ok);
    checks++;
    if (!ok || wa0 !== 32'd128) begin
      fails++;
      $display("FAIL arst_setup: ok=%b waddr=%0d required 1 128", ok, wa0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ts0, wa0, il0, busy0, sd0} !== '0) begin
      fails++;
      $display("FAIL arst_outputs: got %h required 0",
               {ts0, wa0, il0, busy0, sd0});
    end
    @(negedge clk);
    rst = 1'b0;
    run_tile(0, 2, 1, 4, 6, 5, 25, 14, 16, 1'b1, 1'b0, "ignore_start");
  endtask

  task automatic test_random();
    for (int k = 0; k < 15; k++) begin
      int n = int'($urandom_range(1, 20));
      int r = int'($urandom_range(1, 6));
      int c = int'($urandom_range(1, 40));
      int sel = int'($urandom_range(0, 1));
      run_tile(sel, int'($urandom_range(0, n)), int'($urandom_range(0, r)),
               int'($urandom_range(0, c)), n, r, c, (sel == 0) ? 14 : 38,
               16, 1'b0, 1'b1, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_full_tile();
    test_row_split();
    test_partial_channels();
    test_fifo_wait();
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
